// File: rtl/d_ram_dma.sv
`timescale 1ns/1ps
// Byte-copy DMA engine that shares the single-port-pair data RAM with the CPU.
// Reads and writes are pipelined one cycle apart; the CPU is stalled while a copy runs.
module d_ram_dma #(
  parameter int addr_width = 11,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [addr_width:0]   len,
  output logic                  busy,
  output logic                  done,
  input  logic [addr_width-1:0] cpu_w_addr,
  input  logic [addr_width-1:0] cpu_r_addr,
  input  logic [data_width-1:0] cpu_din,
  input  logic                  cpu_w_en,
  input  logic                  cpu_r_en,
  output logic [data_width-1:0] cpu_dout,
  output logic                  cpu_stall,
  output logic [addr_width-1:0] ram_w_addr,
  output logic [addr_width-1:0] ram_r_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_w_en,
  output logic                  ram_r_en,
  input  logic [data_width-1:0] ram_dout,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] src_q, dst_q;
  logic [addr_width:0]   len_q, rd_idx, wr_idx;
  logic                  wr_active;

  // A write is due in every cycle that follows a read: RUN after the first read, and DRAIN.
  assign wr_active = ((state == RUN) && (rd_idx != '0)) || (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
    end else begin
      if (state == IDLE && start && len != '0) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        rd_idx <= '0;
        wr_idx <= '0;
      end
      if (state == RUN) rd_idx <= rd_idx + 1'b1;
      if (wr_active)    wr_idx <= wr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (rd_idx == len_q - 1'b1) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outside a copy the RAM belongs to the CPU; enables are held low while reset is applied.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_w_addr = cpu_w_addr;
    ram_r_addr = cpu_r_addr;
    ram_din    = cpu_din;
    ram_w_en   = cpu_w_en & ~rst;
    ram_r_en   = cpu_r_en & ~rst;
    case (state)
      RUN, DRAIN: begin
        busy       = 1'b1;
        ram_r_en   = (state == RUN);
        ram_r_addr = src_q + rd_idx[addr_width-1:0];
        ram_w_en   = wr_active;
        ram_w_addr = dst_q + wr_idx[addr_width-1:0];
        ram_din    = ram_dout;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_dout  = ram_dout;
  assign cpu_stall = busy;
  assign dbg_state = state;

endmodule
